// File: rtl/seg_arb_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seg_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_e;

  localparam int              DATA_W  = 20;
  localparam int              DIGITS  = 6;
  localparam logic [DATA_W-1:0] MAX_VAL = 20'd999_999;

  // Six decimal digits cannot show more than 999_999; saturate instead of wrapping.
  function automatic logic [DATA_W-1:0] clamp_val(input logic [DATA_W-1:0] v);
    return (v > MAX_VAL) ? MAX_VAL : v;
  endfunction

endpackage

// File: rtl/seg_disp_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request searching upward from rr_ptr+1.
module seg_rr_pick #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  output logic             valid_o,
  output logic [N_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] k;

  always_comb begin
    valid_o  = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    k        = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      k = IDX_W'((int'(rr_ptr_i) + i) % N_REQ);
      if (!valid_o && req_i[k]) begin
        valid_o     = 1'b1;
        onehot_o[k] = 1'b1;
        idx_o       = k;
      end
    end
  end

endmodule

// File: rtl/seg_disp_arbiter.sv
// Round-robin time-sharing of the 6-digit display driver among N_REQ requesters.
// Optional SEG_ARB_PRIO0_EN makes requester 0 a non-preemptible override.
module seg_disp_arbiter
  import seg_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int HOLD_CYC  = 50_000_000,
  parameter int BLANK_CYC = 2_500_000,
  parameter int CNT_W     = 26
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic [N_REQ*DIGITS-1:0]  req_point,
  input  logic [N_REQ-1:0]         req_sign,
  output logic [N_REQ-1:0]         gnt,
  output logic [DATA_W-1:0]        data,
  output logic [DIGITS-1:0]        point,
  output logic                     en,
  output logic                     sign,
  output logic                     busy,
  output state_e                   dbg_state_o
);

  localparam int              IDX_W    = $clog2(N_REQ);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LD = (BLANK_CYC > 0) ? CNT_W'(BLANK_CYC - 1) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DIGITS-1:0] point_q, point_d;
  logic              sign_q, sign_d, en_q, en_d, busy_q, busy_d;

  logic              pick_valid, arb_valid, arb_rr, preempt, owner_sticky;
  logic [N_REQ-1:0]  pick_oh, arb_oh;
  logic [IDX_W-1:0]  pick_idx, arb_idx, src_idx;
  logic              owner_req, others, grant_new, rel;
  logic [DATA_W-1:0] sel_data;
  logic [DIGITS-1:0] sel_point;
  logic              sel_sign;

  seg_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i    (req),
    .rr_ptr_i (rr_ptr_q),
    .valid_o  (pick_valid),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  // Override grants to requester 0 bypass the round-robin pointer entirely.
`ifdef SEG_ARB_PRIO0_EN
  assign arb_valid    = pick_valid | req[0];
  assign arb_oh       = req[0] ? N_REQ'(1) : pick_oh;
  assign arb_idx      = req[0] ? '0 : pick_idx;
  assign arb_rr       = ~req[0];
  assign preempt      = req[0] & (owner_q != '0);
  assign owner_sticky = (owner_q == '0);
`else
  assign arb_valid    = pick_valid;
  assign arb_oh       = pick_oh;
  assign arb_idx      = pick_idx;
  assign arb_rr       = 1'b1;
  assign preempt      = 1'b0;
  assign owner_sticky = 1'b0;
`endif

  assign owner_req = req[owner_q];
  assign others    = |(req & ~gnt_q);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= IDX_W'(N_REQ - 1);
      owner_q  <= '0;
      gnt_q    <= '0;
      data_q   <= '0;
      point_q  <= '0;
      sign_q   <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      data_q   <= data_d;
      point_q  <= point_d;
      sign_q   <= sign_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin : next_state
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_ptr_d  = rr_ptr_q;
    owner_d   = owner_q;
    grant_new = 1'b0;
    rel       = 1'b0;
    case (state_q)
      IDLE: grant_new = arb_valid;
      SHOW: begin
        if (preempt) begin
          rel = 1'b1;
        end else if (cnt_q == '0) begin
          // Sole (or sticky) requester keeps the display without a blank gap.
          if (owner_req && (!others || owner_sticky)) cnt_d = HOLD_LD;
          else                                        rel   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      BLANK: begin
        if (cnt_q == '0) begin
          if (arb_valid) grant_new = 1'b1;
          else           state_d   = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (rel) begin
      if (BLANK_CYC == 0) begin
        if (arb_valid) grant_new = 1'b1;
        else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end else begin
        state_d = BLANK;
        cnt_d   = BLANK_LD;
      end
    end
    if (grant_new) begin
      state_d = SHOW;
      cnt_d   = HOLD_LD;
      owner_d = arb_idx;
      if (arb_rr) rr_ptr_d = arb_idx;
    end
  end

  always_comb begin : output_logic
    src_idx   = grant_new ? arb_idx : owner_q;
    sel_data  = '0;
    sel_point = '0;
    sel_sign  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (src_idx == IDX_W'(i)) begin
        sel_data  = req_data[i*DATA_W +: DATA_W];
        sel_point = req_point[i*DIGITS +: DIGITS];
        sel_sign  = req_sign[i];
      end
    end
    gnt_d   = (state_d == SHOW) ? (grant_new ? arb_oh : gnt_q) : '0;
    en_d    = (state_d == SHOW);
    busy_d  = (state_d != IDLE);
    data_d  = data_q;
    point_d = point_q;
    sign_d  = sign_q;
    // Follow the owner only while it is still requesting; otherwise freeze.
    if (state_d == SHOW && (grant_new || owner_req)) begin
      data_d  = clamp_val(sel_data);
      point_d = sel_point;
      sign_d  = sel_sign;
    end
  end

  assign gnt         = gnt_q;
  assign data        = data_q;
  assign point       = point_q;
  assign en          = en_q;
  assign sign        = sign_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_seg_disp_arbiter.sv
// Directed-vector bench for seg_disp_arbiter with N_REQ=4, HOLD_CYC=8, BLANK_CYC=2.
module tb_seg_disp_arbiter;
  import seg_arb_pkg::*;

  localparam int N_REQ     = 4;
  localparam int HOLD_CYC  = 8;
  localparam int BLANK_CYC = 2;
  localparam int CNT_W     = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [3:0]        req;
  logic [79:0]       req_data;
  logic [23:0]       req_point;
  logic [3:0]        req_sign;
  logic [3:0]        gnt;
  logic [19:0]       data;
  logic [5:0]        point;
  logic              en, sign, busy;
  state_e            dbg_state;

  logic [19:0]       tb_data  [4];
  logic [5:0]        tb_point [4];

  int vectors     = 0;
  int miscompares = 0;

  assign req_data  = {tb_data[3], tb_data[2], tb_data[1], tb_data[0]};
  assign req_point = {tb_point[3], tb_point[2], tb_point[1], tb_point[0]};

  seg_disp_arbiter #(
    .N_REQ(N_REQ), .HOLD_CYC(HOLD_CYC), .BLANK_CYC(BLANK_CYC), .CNT_W(CNT_W)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req         (req),
    .req_data    (req_data),
    .req_point   (req_point),
    .req_sign    (req_sign),
    .gnt         (gnt),
    .data        (data),
    .point       (point),
    .en          (en),
    .sign        (sign),
    .busy        (busy),
    .dbg_state_o (dbg_state)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic tick(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    req       = '0;
    req_sign  = '0;
    for (int i = 0; i < 4; i++) begin
      tb_data[i]  = '0;
      tb_point[i] = '0;
    end

    // Reset values, then idle with no requests.
    #12;
    check("rst_gnt",   32'(gnt), 32'h0);
    check("rst_en",    32'(en), 32'h0);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    sys_rst_n = 1'b1;
    tick(3);
    check("idle_gnt",  32'(gnt), 32'h0);
    check("idle_en",   32'(en), 32'h0);
    check("idle_data", 32'(data), 32'h0);
    check("idle_busy", 32'(busy), 32'h0);

    // Two requesters: 1 wins (search from 0), holds 8, blanks 2, then 2.
    tb_data[1] = 20'd111;
    tb_data[2] = 20'd222;
    req = 4'b0110;
    tick();
    check("rr_first_gnt",  32'(gnt), 32'h2);
    check("rr_first_en",   32'(en), 32'h1);
    check("rr_first_data", 32'(data), 32'd111);
    check("rr_first_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 7; i++) begin
      tick();
      check("rr_hold_gnt", 32'(gnt), 32'h2);
    end
    tick();
    check("rr_blank1_en",   32'(en), 32'h0);
    check("rr_blank1_gnt",  32'(gnt), 32'h0);
    check("rr_blank1_busy", 32'(busy), 32'h1);
    check("rr_blank1_data", 32'(data), 32'd111);
    tick();
    check("rr_blank2_en", 32'(en), 32'h0);
    tick();
    check("rr_second_gnt",  32'(gnt), 32'h4);
    check("rr_second_data", 32'(data), 32'd222);

    // Owner 2 drops immediately: grant kept to the end of hold, then blank, idle.
    req = 4'b0000;
    tick(7);
    check("drop_hold_gnt", 32'(gnt), 32'h4);
    tick();
    check("drop_blank_en",   32'(en), 32'h0);
    check("drop_blank_busy", 32'(busy), 32'h1);
    tick(2);
    check("drop_idle_busy", 32'(busy), 32'h0);
    check("drop_idle_data", 32'(data), 32'd222);

    // Sole requester 3 keeps the display continuously.
    tb_data[3] = 20'd123456;
    req = 4'b1000;
    tick();
    check("solo_gnt",  32'(gnt), 32'h8);
    check("solo_data", 32'(data), 32'd123456);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("solo_en",  32'(en), 32'h1);
      check("solo_gnt", 32'(gnt), 32'h8);
    end
    tb_data[3] = 20'd654321;
    tick();
    check("follow_data", 32'(data), 32'd654321);
    tb_data[3]  = 20'hFFFFF;
    tb_point[3] = 6'b101010;
    req_sign[3] = 1'b1;
    tick();
    check("clamp_max",   32'(data), 32'd999999);
    check("point_pass",  32'(point), 32'h2A);
    check("sign_pass",   32'(sign), 32'h1);
    tb_data[3] = 20'd1_000_000;
    tick();
    check("clamp_edge",  32'(data), 32'd999999);
    tb_data[3] = 20'd999_998;
    tick();
    check("clamp_below", 32'(data), 32'd999998);

    // Asynchronous reset while granted.
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("arst_gnt",   32'(gnt), 32'h0);
    check("arst_en",    32'(en), 32'h0);
    check("arst_data",  32'(data), 32'h0);
    check("arst_point", 32'(point), 32'h0);
    check("arst_sign",  32'(sign), 32'h0);
    check("arst_busy",  32'(busy), 32'h0);
    req = 4'b0000;
    req_sign = '0;
    sys_rst_n = 1'b1;
    tick();

    // Owner 1 requests for 3 cycles with value 42, then drops.
    tb_data[1] = 20'd42;
    req = 4'b0010;
    tick();
    check("frz_gnt",  32'(gnt), 32'h2);
    check("frz_data", 32'(data), 32'd42);
    tick(2);
    req = 4'b0000;
    tb_data[1] = 20'd77;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("frz_hold_gnt",  32'(gnt), 32'h2);
      check("frz_hold_data", 32'(data), 32'd42);
    end
    tick();
    check("frz_blank_gnt",  32'(gnt), 32'h0);
    check("frz_blank_en",   32'(en), 32'h0);
    check("frz_blank_data", 32'(data), 32'd42);
    tick();
    check("frz_blank2_busy", 32'(busy), 32'h1);
    tick();
    check("frz_idle_busy",  32'(busy), 32'h0);
    check("frz_idle_state", 32'(dbg_state), 32'(IDLE));

    // Wrap-around: rr_ptr=1, so requester 0 beats 1, then 1 follows.
    tb_data[0] = 20'd5;
    req = 4'b0011;
    tick();
    check("wrap_gnt",  32'(gnt), 32'h1);
    check("wrap_data", 32'(data), 32'd5);
    tick(8);
    check("wrap_blank_en", 32'(en), 32'h0);
    tick(2);
    check("wrap_next_gnt",  32'(gnt), 32'h2);
    check("wrap_next_data", 32'(data), 32'd77);

    req = 4'b0000;
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    tick();

    // Requester 0 rises while requester 2 owns the display.
    tb_data[2] = 20'd300;
    tb_data[0] = 20'd7;
    req = 4'b0100;
    tick();
    check("ovr_owner_gnt", 32'(gnt), 32'h4);
    tick(2);
    req = 4'b0101;
`ifdef SEG_ARB_PRIO0_EN
    tick();
    check("ovr_cut_gnt", 32'(gnt), 32'h0);
    check("ovr_cut_en",  32'(en), 32'h0);
    tick();
    check("ovr_blank_en", 32'(en), 32'h0);
    tick();
    check("ovr_win_gnt",  32'(gnt), 32'h1);
    check("ovr_win_data", 32'(data), 32'd7);
`else
    tick();
    check("ovr_wait_gnt", 32'(gnt), 32'h4);
    tick(4);
    check("ovr_last_gnt", 32'(gnt), 32'h4);
    tick();
    check("ovr_blank1_en", 32'(en), 32'h0);
    tick();
    check("ovr_blank2_en", 32'(en), 32'h0);
    tick();
    check("ovr_win_gnt",  32'(gnt), 32'h1);
    check("ovr_win_data", 32'(data), 32'd7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
